// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU: steps each instruction through IF/ID/EXE/MEM/WB
// and drives every register/memory write enable and datapath mux select.
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic [2:0] State,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ADRWre,
  output logic       ALUoutDRWre,
  output logic       DBDRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t state, state_nxt;
  logic   halted;

  // Opcode classes; anything outside the fixed map behaves as halt.
  logic is_alu, is_ls, is_lw, is_beq, is_jump, is_jal, is_jr, is_halt;

  always_comb begin
    is_alu  = 1'b0;
    is_ls   = 1'b0;
    is_lw   = 1'b0;
    is_beq  = 1'b0;
    is_jump = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_halt = 1'b0;
    case (Op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b100110, 6'b100111: is_alu = 1'b1;
      6'b110000: is_ls = 1'b1;
      6'b110001: begin is_ls = 1'b1; is_lw = 1'b1; end
      6'b110100: is_beq = 1'b1;
      6'b111000: is_jump = 1'b1;
      6'b111001: begin is_jump = 1'b1; is_jr = 1'b1; end
      6'b111010: begin is_jump = 1'b1; is_jal = 1'b1; end
      default:   is_halt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IF;
      halted <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_ID && is_halt) halted <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:     state_nxt = halted ? S_IF : S_ID;
      S_ID: begin
        if (is_alu)      state_nxt = S_EXE_AL;
        else if (is_ls)  state_nxt = S_EXE_LS;
        else if (is_beq) state_nxt = S_EXE_BR;
        else             state_nxt = S_IF;
      end
      S_EXE_AL: state_nxt = S_WB_AL;
      S_EXE_LS: state_nxt = S_MEM;
      S_MEM:    state_nxt = is_lw ? S_WB_LD : S_IF;
      default:  state_nxt = S_IF;
    endcase
  end

  assign State = state;

  // Enables depend on state; selects depend only on the opcode (and Zero for beq).
  always_comb begin
    PCWre       = 1'b0;
    IRWre       = 1'b0;
    ADRWre      = 1'b0;
    ALUoutDRWre = 1'b0;
    DBDRWre     = 1'b0;
    RegWre      = 1'b0;
    mRD         = 1'b0;
    mWR         = 1'b0;
    ALUOp       = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    ExtSel      = 1'b0;
    RegDst      = 2'b00;
    WrRegDSrc   = 1'b0;
    DBDataSrc   = 1'b0;
    PCSrc       = 2'b00;
    if (!RST) begin
      ExtSel    = 1'b1;
      RegDst    = 2'b10;
      WrRegDSrc = 1'b1;
      case (Op)
        6'b000001, 6'b110100: ALUOp = 3'b001;
        6'b011000:            ALUOp = 3'b010;
        6'b010000, 6'b010010: ALUOp = 3'b011;
        6'b010001:            ALUOp = 3'b100;
        6'b100110:            ALUOp = 3'b101;
        6'b100111:            ALUOp = 3'b110;
        default:              ALUOp = 3'b000;
      endcase
      ALUSrcA = (Op == 6'b011000);
      ALUSrcB = (Op == 6'b000010) || (Op == 6'b010010) || (Op == 6'b100111) || is_ls;
      if (Op == 6'b010010 || Op == 6'b100111) ExtSel = 1'b0;
      if (Op == 6'b000010 || Op == 6'b010010 || Op == 6'b100111 || is_lw) RegDst = 2'b01;
      if (is_jal) begin
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
      end
      DBDataSrc = is_lw;
      if (is_beq && Zero) PCSrc = 2'b01;
      else if (is_jr)     PCSrc = 2'b10;
      else if (is_jump)   PCSrc = 2'b11;

      if (!halted) begin
        case (state)
          S_IF:     IRWre = 1'b1;
          S_ID: begin
            ADRWre = 1'b1;
            PCWre  = is_jump;
            RegWre = is_jal;
          end
          S_EXE_AL, S_EXE_LS: ALUoutDRWre = 1'b1;
          S_EXE_BR: begin
            ALUoutDRWre = 1'b1;
            PCWre       = 1'b1;
          end
          S_MEM: begin
            mRD   = is_lw;
            mWR   = !is_lw;
            PCWre = !is_lw;
          end
          S_WB_LD: begin
            DBDRWre = 1'b1;
            RegWre  = 1'b1;
            PCWre   = 1'b1;
          end
          S_WB_AL: begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
